// File: rtl/centroid_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : centroid_result_writer
// Purpose  : Captures the final k-means centroids on the core's start pulse,
//            then writes them one per handshake into the host register file.
//            When the last write is accepted, it raises a level interrupt.
//            Optional build macro CENT_WRITER_STATUS_WORD_EN adds a trailing
//            status word, {max_iter_reached, iter_cnt}, after the centroids.
// Revision : 1.0  initial release
// ============================================================================
module centroid_result_writer #(
  parameter int CENTROID_NUM   = 8,
  parameter int LOG2_CENT_NUM  = 3,
  parameter int DATA_WIDTH     = 91,
  parameter int ADDR_WIDTH     = 9,
  parameter int FIRST_CENT_REG = 4,
  parameter int ITER_WIDTH     = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [CENTROID_NUM*DATA_WIDTH-1:0] centroids_flat,
  input  logic [ITER_WIDTH-1:0]              iter_cnt,
  input  logic                               max_iter_reached,
  input  logic                               reg_ack,
  input  logic                               int_clr,
  output logic [ADDR_WIDTH-1:0]              reg_num,
  output logic                               reg_w_r,
  output logic [DATA_WIDTH-1:0]              reg_write_data,
  output logic                               busy,
  output logic                               interuptt
);

  localparam logic [LOG2_CENT_NUM-1:0] LAST_IDX = LOG2_CENT_NUM'(CENTROID_NUM - 1);

  typedef enum logic [1:0] {IDLE, WRITE, STATUS, DONE} state_t;

  state_t                   state;
  state_t                   next_state;
  logic [LOG2_CENT_NUM-1:0] index;
  logic [LOG2_CENT_NUM-1:0] next_index;
  logic [DATA_WIDTH-1:0]    snap [CENTROID_NUM];
  logic                     write_done;
  logic                     at_last;

  assign write_done = reg_w_r & reg_ack;
  assign at_last    = (index == LAST_IDX);
  assign next_index = index + LOG2_CENT_NUM'(1);

`ifdef CENT_WRITER_STATUS_WORD_EN
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(FIRST_CENT_REG + CENTROID_NUM);
  logic [ITER_WIDTH-1:0] snap_iter;
  logic                  snap_max;
  logic [DATA_WIDTH-1:0] status_word;
  assign status_word = DATA_WIDTH'({snap_max, snap_iter});

  // Iteration info is captured alongside the centroids so the core may restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_iter <= '0;
      snap_max  <= 1'b0;
    end else if (state == IDLE && start) begin
      snap_iter <= iter_cnt;
      snap_max  <= max_iter_reached;
    end
  end
`else
  logic unused_status_inputs;
  assign unused_status_inputs = ^{iter_cnt, max_iter_reached};
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode; a write advances only on an accepted handshake.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = WRITE;
      WRITE: if (write_done && at_last) begin
`ifdef CENT_WRITER_STATUS_WORD_EN
               next_state = STATUS;
`else
               next_state = DONE;
`endif
             end
`ifdef CENT_WRITER_STATUS_WORD_EN
      STATUS: if (write_done) next_state = DONE;
`endif
      DONE:  if (int_clr) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Snapshot, index and registered bus outputs; the next word is presented
  // on the same edge that accepts the current one, allowing back-to-back writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index          <= '0;
      reg_num        <= '0;
      reg_w_r        <= 1'b0;
      reg_write_data <= '0;
      busy           <= 1'b0;
      interuptt      <= 1'b0;
      for (int k = 0; k < CENTROID_NUM; k++) snap[k] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          for (int k = 0; k < CENTROID_NUM; k++)
            snap[k] <= centroids_flat[k*DATA_WIDTH +: DATA_WIDTH];
          index          <= '0;
          reg_w_r        <= 1'b1;
          reg_num        <= ADDR_WIDTH'(FIRST_CENT_REG);
          reg_write_data <= centroids_flat[DATA_WIDTH-1:0];
          busy           <= 1'b1;
        end
        WRITE: if (write_done) begin
          if (!at_last) begin
            index          <= next_index;
            reg_num        <= ADDR_WIDTH'(FIRST_CENT_REG) + ADDR_WIDTH'(next_index);
            reg_write_data <= snap[next_index];
          end else begin
`ifdef CENT_WRITER_STATUS_WORD_EN
            reg_num        <= STATUS_ADDR;
            reg_write_data <= status_word;
`else
            reg_w_r        <= 1'b0;
            interuptt      <= 1'b1;
`endif
          end
        end
`ifdef CENT_WRITER_STATUS_WORD_EN
        STATUS: if (write_done) begin
          reg_w_r   <= 1'b0;
          interuptt <= 1'b1;
        end
`endif
        DONE: if (int_clr) begin
          interuptt <= 1'b0;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_centroid_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_centroid_result_writer
// Purpose  : Self-checking bench; expected write sequences come from a
//            list-based model of the result (address, word) pairs.
// Revision : 1.0  initial release
// ============================================================================
module tb_centroid_result_writer;
  localparam int CN = 8;
  localparam int DW = 91;
  localparam int AW = 9;
  localparam int FR = 4;
  localparam int IW = 8;
`ifdef CENT_WRITER_STATUS_WORD_EN
  localparam int NWR = CN + 1;
`else
  localparam int NWR = CN;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CN*DW-1:0] centroids_flat = '0;
  logic [IW-1:0]    iter_cnt = '0;
  logic             max_iter_reached = 1'b0;
  logic             reg_ack = 1'b0;
  logic             int_clr = 1'b0;
  logic [AW-1:0]    reg_num;
  logic             reg_w_r;
  logic [DW-1:0]    reg_write_data;
  logic             busy;
  logic             interuptt;

  centroid_result_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .centroids_flat(centroids_flat),
    .iter_cnt(iter_cnt), .max_iter_reached(max_iter_reached), .reg_ack(reg_ack),
    .int_clr(int_clr), .reg_num(reg_num), .reg_w_r(reg_w_r),
    .reg_write_data(reg_write_data), .busy(busy), .interuptt(interuptt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: the result that should appear on the bus for one start.
  logic [DW-1:0] words [CN];
  logic [DW-1:0] model_words [CN];
  logic [IW-1:0] model_iter;
  logic          model_max;

  // Observed writes from the most recent sequence.
  logic [AW-1:0] got_addr [32];
  logic [DW-1:0] got_data [32];
  int            got_n;
  int            lat;
  bit            hold_ok, busy_ok, timed_out;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  function automatic logic [AW-1:0] exp_addr(int k);
    return AW'(FR + k);
  endfunction

  function automatic logic [DW-1:0] exp_data(int k);
    if (k < CN) return model_words[k];
    return DW'({model_max, model_iter});
  endfunction

  task automatic load_inputs();
    for (int k = 0; k < CN; k++) centroids_flat[k*DW +: DW] = words[k];
  endtask

  task automatic pulse_start();
    for (int k = 0; k < CN; k++) model_words[k] = words[k];
    model_iter = iter_cnt;
    model_max  = max_iter_reached;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_irq();
    int_clr = 1'b1;
    step();
    int_clr = 1'b0;
  endtask

  // Drives reg_ack per mode (0: always 1, 1: 0,0,1 per write, 2: random) and
  // records every accepted write until the interrupt rises.
  task automatic collect(input int mode, input bit perturb);
    int held;
    logic [AW-1:0] pn;
    logic [DW-1:0] pd;
    bit acc, pw;
    held = 0; got_n = 0; lat = 0;
    hold_ok = 1; busy_ok = 1; timed_out = 1;
    for (int k = 0; k < 32; k++) begin got_addr[k] = 'x; got_data[k] = 'x; end
    for (int cyc = 0; cyc < 300; cyc++) begin
      case (mode)
        0:       reg_ack = 1'b1;
        1:       reg_ack = (held == 2);
        default: reg_ack = 1'($urandom_range(0, 1));
      endcase
      if (perturb && cyc == 1) begin
        centroids_flat = '1; start = 1'b1; int_clr = 1'b1;
      end else if (perturb && cyc == 2) begin
        start = 1'b0; int_clr = 1'b0;
      end
      pn = reg_num; pd = reg_write_data; pw = reg_w_r;
      acc = reg_w_r && reg_ack;
      if (acc) begin
        got_addr[got_n] = reg_num;
        got_data[got_n] = reg_write_data;
        if (got_n < 31) got_n++;
        held = 0;
      end else if (reg_w_r) held++;
      step();
      lat++;
      if (busy !== 1'b1) busy_ok = 0;
      if (pw && !acc && (reg_w_r !== 1'b1 || reg_num !== pn || reg_write_data !== pd)) hold_ok = 0;
      if (interuptt === 1'b1) begin timed_out = 0; break; end
    end
    reg_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_cmp++;
    if ({reg_num, reg_w_r, reg_write_data, busy, interuptt} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got num=%0d wr=%b data=%h busy=%b irq=%b, expected all 0",
               reg_num, reg_w_r, reg_write_data, busy, interuptt);
    end
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    for (int k = 0; k < CN; k++) words[k] = DW'(k + 1);
    iter_cnt = IW'($urandom); max_iter_reached = 1'($urandom);
    load_inputs();
    pulse_start();
    n_cmp++;
    if (reg_w_r !== 1'b1 || busy !== 1'b1 || reg_num !== AW'(FR) || reg_write_data !== DW'(1)) begin
      n_err++;
      $display("FAIL basic_first: got wr=%b busy=%b num=%0d data=%h, expected wr=1 busy=1 num=%0d data=1",
               reg_w_r, busy, reg_num, reg_write_data, FR);
    end
    collect(0, 0);
    n_cmp++;
    if (timed_out || got_n !== NWR || lat !== NWR || !busy_ok) begin
      n_err++;
      $display("FAIL basic_seq: got writes=%0d cycles=%0d timeout=%b busy_ok=%b, expected writes=%0d cycles=%0d",
               got_n, lat, timed_out, busy_ok, NWR, NWR);
    end
    for (int k = 0; k < NWR; k++) begin
      n_cmp++;
      if (got_addr[k] !== exp_addr(k) || got_data[k] !== exp_data(k)) begin
        n_err++;
        $display("FAIL basic_write[%0d]: got addr=%0d data=%h, expected addr=%0d data=%h",
                 k, got_addr[k], got_data[k], exp_addr(k), exp_data(k));
      end
    end
    step(); step();
    n_cmp++;
    if (interuptt !== 1'b1 || busy !== 1'b1 || reg_w_r !== 1'b0) begin
      n_err++;
      $display("FAIL irq_level: got irq=%b busy=%b wr=%b, expected irq=1 busy=1 wr=0",
               interuptt, busy, reg_w_r);
    end
    clear_irq();
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < CN; k++) words[k] = rand_word();
    iter_cnt = IW'($urandom); max_iter_reached = 1'($urandom);
    load_inputs();
    pulse_start();
    collect(1, 0);
    n_cmp++;
    if (timed_out || got_n !== NWR || lat !== 3*NWR || !hold_ok) begin
      n_err++;
      $display("FAIL backpressure_seq: got writes=%0d cycles=%0d hold_ok=%b timeout=%b, expected writes=%0d cycles=%0d hold_ok=1",
               got_n, lat, hold_ok, timed_out, NWR, 3*NWR);
    end
    for (int k = 0; k < NWR; k++) begin
      n_cmp++;
      if (got_addr[k] !== exp_addr(k) || got_data[k] !== exp_data(k)) begin
        n_err++;
        $display("FAIL backpressure_write[%0d]: got addr=%0d data=%h, expected addr=%0d data=%h",
                 k, got_addr[k], got_data[k], exp_addr(k), exp_data(k));
      end
    end
    clear_irq();
  endtask

  task automatic test_snapshot();
    for (int k = 0; k < CN; k++) words[k] = DW'(k + 1);
    iter_cnt = IW'($urandom); max_iter_reached = 1'($urandom);
    load_inputs();
    pulse_start();
    collect(0, 1);
    n_cmp++;
    if (timed_out || got_n !== NWR || lat !== NWR) begin
      n_err++;
      $display("FAIL snapshot_seq: got writes=%0d cycles=%0d timeout=%b, expected writes=%0d cycles=%0d",
               got_n, lat, timed_out, NWR, NWR);
    end
    for (int k = 0; k < NWR; k++) begin
      n_cmp++;
      if (got_addr[k] !== exp_addr(k) || got_data[k] !== exp_data(k)) begin
        n_err++;
        $display("FAIL snapshot_write[%0d]: got addr=%0d data=%h, expected addr=%0d data=%h",
                 k, got_addr[k], got_data[k], exp_addr(k), exp_data(k));
      end
    end
    step(); step(); step();
    n_cmp++;
    if (reg_w_r !== 1'b0 || interuptt !== 1'b1) begin
      n_err++;
      $display("FAIL snapshot_no_restart: got wr=%b irq=%b, expected wr=0 irq=1", reg_w_r, interuptt);
    end
  endtask

  task automatic test_int_clr();
    bit quiet;
    int_clr = 1'b1; start = 1'b1;
    step();
    int_clr = 1'b0; start = 1'b0;
    n_cmp++;
    if (interuptt !== 1'b0 || busy !== 1'b0 || reg_w_r !== 1'b0) begin
      n_err++;
      $display("FAIL int_clr: got irq=%b busy=%b wr=%b, expected irq=0 busy=0 wr=0",
               interuptt, busy, reg_w_r);
    end
    quiet = 1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (reg_w_r !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    n_cmp++;
    if (!quiet) begin
      n_err++;
      $display("FAIL int_clr_start_ignored: got activity=1, expected activity=0");
    end
    for (int k = 0; k < CN; k++) words[k] = rand_word();
    iter_cnt = IW'($urandom); max_iter_reached = 1'($urandom);
    load_inputs();
    pulse_start();
    collect(2, 0);
    n_cmp++;
    if (timed_out || got_n !== NWR || !hold_ok) begin
      n_err++;
      $display("FAIL restart_seq: got writes=%0d hold_ok=%b timeout=%b, expected writes=%0d",
               got_n, hold_ok, timed_out, NWR);
    end
    for (int k = 0; k < NWR; k++) begin
      n_cmp++;
      if (got_addr[k] !== exp_addr(k) || got_data[k] !== exp_data(k)) begin
        n_err++;
        $display("FAIL restart_write[%0d]: got addr=%0d data=%h, expected addr=%0d data=%h",
                 k, got_addr[k], got_data[k], exp_addr(k), exp_data(k));
      end
    end
    clear_irq();
  endtask

  task automatic test_reset_midop();
    bit reached, quiet;
    for (int k = 0; k < CN; k++) words[k] = rand_word();
    load_inputs();
    pulse_start();
    reached = 0;
    for (int c = 0; c < 20; c++) begin
      if (reg_num === AW'(FR + 3)) begin reached = 1; break; end
      reg_ack = 1'b1;
      step();
    end
    reg_ack = 1'b0;
    n_cmp++;
    if (!reached) begin
      n_err++;
      $display("FAIL midop_reach_index3: got reg_num=%0d, expected %0d", reg_num, FR + 3);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({reg_num, reg_w_r, reg_write_data, busy, interuptt} !== '0) begin
      n_err++;
      $display("FAIL midop_reset: got num=%0d wr=%b data=%h busy=%b irq=%b, expected all 0",
               reg_num, reg_w_r, reg_write_data, busy, interuptt);
    end
    #3 rst_n = 1'b1;
    quiet = 1;
    for (int c = 0; c < 5; c++) begin
      reg_ack = 1'b1;
      step();
      if (reg_w_r !== 1'b0 || interuptt !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    reg_ack = 1'b0;
    n_cmp++;
    if (!quiet) begin
      n_err++;
      $display("FAIL midop_after_release: got activity=1, expected activity=0");
    end
  endtask

  task automatic test_status_and_random();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < CN; k++) words[k] = rand_word();
      if (r == 0) begin iter_cnt = 8'd23; max_iter_reached = 1'b1; end
      else begin iter_cnt = IW'($urandom); max_iter_reached = 1'($urandom); end
      load_inputs();
      pulse_start();
      collect(2, 0);
      n_cmp++;
      if (timed_out || got_n !== NWR || !hold_ok) begin
        n_err++;
        $display("FAIL random_seq[%0d]: got writes=%0d hold_ok=%b timeout=%b, expected writes=%0d",
                 r, got_n, hold_ok, timed_out, NWR);
      end
      for (int k = 0; k < NWR; k++) begin
        n_cmp++;
        if (got_addr[k] !== exp_addr(k) || got_data[k] !== exp_data(k)) begin
          n_err++;
          $display("FAIL random_write[%0d][%0d]: got addr=%0d data=%h, expected addr=%0d data=%h",
                   r, k, got_addr[k], got_data[k], exp_addr(k), exp_data(k));
        end
      end
      if (r == 0) begin
        n_cmp++;
`ifdef CENT_WRITER_STATUS_WORD_EN
        if (got_addr[CN] !== 9'd12 || got_data[CN] !== 91'h117) begin
          n_err++;
          $display("FAIL status_word: got addr=%0d data=%h, expected addr=12 data=117",
                   got_addr[CN], got_data[CN]);
        end
`else
        if (got_n !== 8) begin
          n_err++;
          $display("FAIL no_status_word: got writes=%0d, expected 8", got_n);
        end
`endif
      end
      clear_irq();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_int_clr();
    test_reset_midop();
    test_status_and_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
